// File: rtl/time_cmd_arbiter_if.sv
// Bus bundle for time_cmd_arbiter: event inputs, control pulses and status.
// CMD_ECHO_EN adds the UART echo handshake signals.
interface time_cmd_arbiter_if #(
    parameter int FIFO_DEPTH = 4
);
    logic [4:0]                    i_btn_evt;
    logic [7:0]                    i_rx_data;
    logic                          i_rx_done;
    logic                          sw_convert;
    logic [4:0]                    o_control;
    logic                          o_busy;
    logic                          o_drop;
    logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt;
`ifdef CMD_ECHO_EN
    logic                          i_tx_busy;
    logic                          o_tx_start;
    logic [7:0]                    o_tx_data;

    modport master (output i_btn_evt, i_rx_data, i_rx_done, sw_convert, i_tx_busy,
                    input  o_control, o_busy, o_drop, o_fifo_cnt, o_tx_start, o_tx_data);
    modport slave  (input  i_btn_evt, i_rx_data, i_rx_done, sw_convert, i_tx_busy,
                    output o_control, o_busy, o_drop, o_fifo_cnt, o_tx_start, o_tx_data);
`else
    modport master (output i_btn_evt, i_rx_data, i_rx_done, sw_convert,
                    input  o_control, o_busy, o_drop, o_fifo_cnt);
    modport slave  (input  i_btn_evt, i_rx_data, i_rx_done, sw_convert,
                    output o_control, o_busy, o_drop, o_fifo_cnt);
`endif
endinterface

// File: rtl/time_cmd_arbiter.sv
// Merges button events and UART command bytes into spaced one-hot control pulses.
// Optional CMD_ECHO_EN: echoes each issued command letter over the UART transmitter.
module time_cmd_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    time_cmd_arbiter_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PULSE, GAP} state_e;

    state_e          state_q, state_d;
    logic [2:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            pend_vld_q, pend_vld_d;
    logic [2:0]      pend_code_q, pend_code_d;
    logic [2:0]      code_q, code_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [4:0]      ctrl_q, ctrl_d;
    logic            busy_q, busy_d, drop_q, drop_d;
    logic            sw_prev_q, flush_q, flush_d;

    logic            wr_en, pop, room, sw_edge, gap_hold;
    logic [2:0]      wr_code, btn_code, rx_code;
    logic            btn_ok, btn_multi, rx_hit, rx_ok;

    function automatic logic mode_ok(input logic [2:0] c, input logic sw);
        return (c <= 3'd2) ? !sw : sw;
    endfunction

`ifdef CMD_ECHO_EN
    logic       echo_vld_q, echo_vld_d, tx_start_q, tx_start_d;
    logic [7:0] echo_data_q, echo_data_d;

    always_comb begin
        echo_vld_d  = echo_vld_q;
        echo_data_d = echo_data_q;
        tx_start_d  = 1'b0;
        if (echo_vld_q && !bus.i_tx_busy) begin
            tx_start_d = 1'b1;
            echo_vld_d = 1'b0;
        end
        if (state_q == PULSE) begin
            echo_vld_d = 1'b1;
            case (code_q)
                3'd0:    echo_data_d = 8'h48;
                3'd1:    echo_data_d = 8'h4D;
                3'd2:    echo_data_d = 8'h53;
                3'd3:    echo_data_d = 8'h52;
                default: echo_data_d = 8'h43;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_vld_q  <= 1'b0;
            echo_data_q <= 8'h00;
            tx_start_q  <= 1'b0;
        end else begin
            echo_vld_q  <= echo_vld_d;
            echo_data_q <= echo_data_d;
            tx_start_q  <= tx_start_d;
        end
    end

    assign bus.o_tx_start = tx_start_q;
    assign bus.o_tx_data  = echo_data_q;
    assign gap_hold       = echo_vld_q;
`else
    assign gap_hold = 1'b0;
`endif

    // Event decode: lowest button bit wins, UART letters are case-insensitive.
    always_comb begin
        btn_code = 3'd0;
        for (int i = 4; i >= 0; i--)
            if (bus.i_btn_evt[i]) btn_code = 3'(i);
        btn_multi = |(bus.i_btn_evt & (bus.i_btn_evt - 5'd1));
        btn_ok    = (|bus.i_btn_evt) && mode_ok(btn_code, bus.sw_convert);
        rx_hit  = 1'b1;
        rx_code = 3'd0;
        case (bus.i_rx_data | 8'h20)
            8'h68:   rx_code = 3'd0;
            8'h6d:   rx_code = 3'd1;
            8'h73:   rx_code = 3'd2;
            8'h72:   rx_code = 3'd3;
            8'h63:   rx_code = 3'd4;
            default: rx_hit  = 1'b0;
        endcase
        rx_ok = bus.i_rx_done && rx_hit && mode_ok(rx_code, bus.sw_convert);
    end

    assign sw_edge = bus.sw_convert != sw_prev_q;
    // Popping is frozen around a mode change so nothing stale issues after the flush.
    assign pop  = (state_q == IDLE) && (cnt_q != '0) && !flush_q && !sw_edge;
    assign room = (cnt_q != FULL) || pop;

    always_comb begin
        wr_en       = 1'b0;
        wr_code     = 3'd0;
        pend_vld_d  = pend_vld_q;
        pend_code_d = pend_code_q;
        drop_d      = btn_multi;
        if (btn_ok) begin
            wr_en   = room;
            wr_code = btn_code;
            if (!room) drop_d = 1'b1;
            if (rx_ok) begin
                if (pend_vld_q) drop_d = 1'b1;
                else begin
                    pend_vld_d  = 1'b1;
                    pend_code_d = rx_code;
                end
            end
        end else if (pend_vld_q) begin
            // Pending entry waits for room rather than being lost.
            wr_en   = room;
            wr_code = pend_code_q;
            if (room) pend_vld_d = 1'b0;
            if (rx_ok) drop_d = 1'b1;
        end else if (rx_ok) begin
            wr_en   = room;
            wr_code = rx_code;
            if (!room) drop_d = 1'b1;
        end
        if (flush_q) begin
            wr_en      = 1'b0;
            pend_vld_d = 1'b0;
            drop_d     = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        gap_d    = gap_q;
        ctrl_d   = 5'd0;
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
        flush_d  = sw_edge;
        if (flush_q) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
        case (state_q)
            IDLE: if (pop) begin
                code_d  = mem_q[rd_ptr_q];
                state_d = PULSE;
            end
            PULSE: begin
                ctrl_d  = 5'(5'd1 << code_q);
                gap_d   = GW'(GAP_CYCLES - 1);
                state_d = GAP;
            end
            GAP: begin
                if (gap_q != '0)  gap_d = gap_q - 1'b1;
                else if (!gap_hold) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (cnt_d != '0) || (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_code;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            pend_vld_q  <= 1'b0;
            pend_code_q <= 3'd0;
            code_q      <= 3'd0;
            gap_q       <= '0;
            ctrl_q      <= 5'd0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
            sw_prev_q   <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_code_q <= pend_code_d;
            code_q      <= code_d;
            gap_q       <= gap_d;
            ctrl_q      <= ctrl_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
            sw_prev_q   <= bus.sw_convert;
            flush_q     <= flush_d;
        end
    end

    assign bus.o_control  = ctrl_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_drop     = drop_q;
    assign bus.o_fifo_cnt = cnt_q;
endmodule
